// File: rtl/decode_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, ALU op codes,
// writeback-select encodings, immediate formats and the immediate builder.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SRC1 = 4'b1100;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_SH   = 3'd2,
    IMM_S    = 3'd3,
    IMM_B    = 3'd4,
    IMM_U    = 3'd5,
    IMM_J    = 3'd6
  } imm_fmt_e;

  // 32-bit immediate; callers sign-extend to XLEN (shamt is already positive)
  function automatic logic [31:0] imm32(imm_fmt_e fmt, logic [31:0] inst);
    logic [31:0] v;
    case (fmt)
      IMM_I:   v = {{20{inst[31]}}, inst[31:20]};
      IMM_SH:  v = {27'd0, inst[24:20]};
      IMM_S:   v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   v = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   v = {inst[31:12], 12'd0};
      IMM_J:   v = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction -> control bundle decoder.
// Also reports which source registers the instruction really reads, so the
// stage can limit load-use stalls to true dependencies.
// Optional multiply/divide decode is enabled by defining RV32M_EN.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic [31:0]      i_inst,
  output logic [3:0]       o_alu_op,
  output logic [XLEN-1:0]  o_imm,
  output logic [RF_AW-1:0] o_rf_ra0,
  output logic [RF_AW-1:0] o_rf_ra1,
  output logic [RF_AW-1:0] o_rf_wa,
  output logic             o_rf_we,
  output logic             o_alu_src0_sel,
  output logic             o_alu_src1_sel,
  output logic             o_mem_re,
  output logic             o_mem_we,
  output logic [2:0]       o_mem_width,
  output logic             o_br_en,
  output logic [2:0]       o_br_type,
  output logic             o_jump,
  output logic [1:0]       o_wb_sel,
  output logic             o_mdu_en,
  output logic [2:0]       o_mdu_op,
  output logic             o_illegal,
  output logic             o_use_ra0,
  output logic             o_use_ra1
);

  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_f7;

  assign w_opc = i_inst[6:0];
  assign w_rd  = i_inst[11:7];
  assign w_f3  = i_inst[14:12];
  assign w_rs1 = i_inst[19:15];
  assign w_rs2 = i_inst[24:20];
  assign w_f7  = i_inst[31:25];

  imm_fmt_e w_fmt;
  logic     w_wr;
  logic     w_mem_re;
  logic     w_mem_we;
  logic     w_br;
  logic     w_jump;
  logic     w_mdu;
  logic     w_bad;
  logic     w_rf_bad;

  // opcode / funct decode into raw (ungated) control fields
  always_comb begin
    o_alu_op       = ALU_ADD;
    w_fmt          = IMM_NONE;
    o_use_ra0      = 1'b0;
    o_use_ra1      = 1'b0;
    w_wr           = 1'b0;
    o_alu_src0_sel = 1'b1;
    o_alu_src1_sel = 1'b0;
    w_mem_re       = 1'b0;
    w_mem_we       = 1'b0;
    w_br           = 1'b0;
    w_jump         = 1'b0;
    o_wb_sel       = WB_ALU;
    w_mdu          = 1'b0;
    w_bad          = 1'b0;
    case (w_opc)
      OPC_OP: begin
        o_use_ra0      = 1'b1;
        o_use_ra1      = 1'b1;
        w_wr           = 1'b1;
        o_alu_src1_sel = 1'b1;
        o_alu_op       = {i_inst[30], w_f3};
        if (w_f7 == 7'b0000000) begin
          w_bad = 1'b0;
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_bad = 1'b0;
`ifdef RV32M_EN
        end else if (w_f7 == 7'b0000001) begin
          w_mdu = 1'b1;
`endif
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        o_use_ra0 = 1'b1;
        w_wr      = 1'b1;
        if (w_f3 == 3'b001) begin
          w_fmt    = IMM_SH;
          o_alu_op = {i_inst[30], w_f3};
          w_bad    = (w_f7 != 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          w_fmt    = IMM_SH;
          o_alu_op = {i_inst[30], w_f3};
          w_bad    = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
        end else begin
          // bit 30 is immediate data here, not an op modifier
          w_fmt    = IMM_I;
          o_alu_op = {1'b0, w_f3};
        end
      end
      OPC_LUI: begin
        w_wr     = 1'b1;
        w_fmt    = IMM_U;
        o_alu_op = ALU_SRC1;
      end
      OPC_AUIPC: begin
        w_wr           = 1'b1;
        w_fmt          = IMM_U;
        o_alu_src0_sel = 1'b0;
      end
      OPC_LOAD: begin
        o_use_ra0 = 1'b1;
        w_wr      = 1'b1;
        w_fmt     = IMM_I;
        w_mem_re  = 1'b1;
        o_wb_sel  = WB_MEM;
        w_bad     = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        o_use_ra0 = 1'b1;
        o_use_ra1 = 1'b1;
        w_fmt     = IMM_S;
        w_mem_we  = 1'b1;
        w_bad     = (w_f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        o_use_ra0      = 1'b1;
        o_use_ra1      = 1'b1;
        w_fmt          = IMM_B;
        o_alu_src0_sel = 1'b0;
        w_br           = 1'b1;
        w_bad          = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_JAL: begin
        w_wr           = 1'b1;
        w_fmt          = IMM_J;
        o_alu_src0_sel = 1'b0;
        w_jump         = 1'b1;
        o_wb_sel       = WB_PC4;
      end
      OPC_JALR: begin
        o_use_ra0 = 1'b1;
        w_wr      = 1'b1;
        w_fmt     = IMM_I;
        w_jump    = 1'b1;
        o_wb_sel  = WB_PC4;
        w_bad     = (w_f3 != 3'b000);
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  // reduced register files reject any referenced index in the upper half
  assign w_rf_bad = (RF_AW < 5) &&
                    ((o_use_ra0 && w_rs1[4]) || (o_use_ra1 && w_rs2[4]) || (w_wr && w_rd[4]));

  assign o_illegal   = w_bad || w_rf_bad;
  assign o_rf_we     = w_wr && (w_rd != 5'd0) && !o_illegal;
  assign o_mem_re    = w_mem_re && !o_illegal;
  assign o_mem_we    = w_mem_we && !o_illegal;
  assign o_br_en     = w_br && !o_illegal;
  assign o_jump      = w_jump && !o_illegal;
  assign o_mdu_en    = w_mdu && !o_illegal;
  assign o_mdu_op    = w_mdu ? w_f3 : 3'd0;
  assign o_mem_width = (w_mem_re || w_mem_we) ? w_f3 : 3'd0;
  assign o_br_type   = w_br ? w_f3 : 3'd0;
  assign o_rf_ra0    = o_use_ra0 ? w_rs1[RF_AW-1:0] : '0;
  assign o_rf_ra1    = o_use_ra1 ? w_rs2[RF_AW-1:0] : '0;
  assign o_rf_wa     = w_wr ? w_rd[RF_AW-1:0] : '0;
  assign o_imm       = XLEN'($signed(imm32(w_fmt, i_inst)));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between IF/ID and EX: valid/ready on both
// sides, flush, single-bubble load-use stall and illegal flagging.
// Optional multiply/divide decode is enabled by defining RV32M_EN
// (otherwise the mdu outputs stay 0 and M encodings are illegal).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_alu_op,
  output logic [XLEN-1:0]  out_imm,
  output logic [RF_AW-1:0] out_rf_ra0,
  output logic [RF_AW-1:0] out_rf_ra1,
  output logic [RF_AW-1:0] out_rf_wa,
  output logic             out_rf_we,
  output logic             out_alu_src0_sel,
  output logic             out_alu_src1_sel,
  output logic             out_mem_re,
  output logic             out_mem_we,
  output logic [2:0]       out_mem_width,
  output logic             out_br_en,
  output logic [2:0]       out_br_type,
  output logic             out_jump,
  output logic [1:0]       out_wb_sel,
  output logic             out_mdu_en,
  output logic [2:0]       out_mdu_op,
  output logic             out_illegal
);

  logic [3:0]       w_alu_op;
  logic [XLEN-1:0]  w_imm;
  logic [RF_AW-1:0] w_ra0;
  logic [RF_AW-1:0] w_ra1;
  logic [RF_AW-1:0] w_wa;
  logic             w_rf_we;
  logic             w_src0_sel;
  logic             w_src1_sel;
  logic             w_mem_re;
  logic             w_mem_we;
  logic [2:0]       w_mem_width;
  logic             w_br_en;
  logic [2:0]       w_br_type;
  logic             w_jump;
  logic [1:0]       w_wb_sel;
  logic             w_mdu_en;
  logic [2:0]       w_mdu_op;
  logic             w_illegal;
  logic             w_use_ra0;
  logic             w_use_ra1;

  decode_comb #(
    .XLEN  (XLEN),
    .RF_AW (RF_AW)
  ) u_decode_comb (
    .i_inst         (in_inst),
    .o_alu_op       (w_alu_op),
    .o_imm          (w_imm),
    .o_rf_ra0       (w_ra0),
    .o_rf_ra1       (w_ra1),
    .o_rf_wa        (w_wa),
    .o_rf_we        (w_rf_we),
    .o_alu_src0_sel (w_src0_sel),
    .o_alu_src1_sel (w_src1_sel),
    .o_mem_re       (w_mem_re),
    .o_mem_we       (w_mem_we),
    .o_mem_width    (w_mem_width),
    .o_br_en        (w_br_en),
    .o_br_type      (w_br_type),
    .o_jump         (w_jump),
    .o_wb_sel       (w_wb_sel),
    .o_mdu_en       (w_mdu_en),
    .o_mdu_op       (w_mdu_op),
    .o_illegal      (w_illegal),
    .o_use_ra0      (w_use_ra0),
    .o_use_ra1      (w_use_ra1)
  );

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [3:0]       r_alu_op;
  logic [XLEN-1:0]  r_imm;
  logic [RF_AW-1:0] r_ra0;
  logic [RF_AW-1:0] r_ra1;
  logic [RF_AW-1:0] r_wa;
  logic             r_rf_we;
  logic             r_src0_sel;
  logic             r_src1_sel;
  logic             r_mem_re;
  logic             r_mem_we;
  logic [2:0]       r_mem_width;
  logic             r_br_en;
  logic [2:0]       r_br_type;
  logic             r_jump;
  logic [1:0]       r_wb_sel;
  logic             r_mdu_en;
  logic [2:0]       r_mdu_op;
  logic             r_illegal;
  logic             r_lp;
  logic [RF_AW-1:0] r_lp_rd;

  logic w_hazard;
  logic w_accept;
  logic w_xfer;

  // load-use: the offered instruction reads the rd of a load that just left
  assign w_hazard = r_lp && (r_lp_rd != '0) &&
                    ((w_use_ra0 && (w_ra0 == r_lp_rd)) || (w_use_ra1 && (w_ra1 == r_lp_rd)));
  assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_valid && out_ready;

  // output bundle register and load-pending tracker; flush outranks accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_alu_op    <= '0;
      r_imm       <= '0;
      r_ra0       <= '0;
      r_ra1       <= '0;
      r_wa        <= '0;
      r_rf_we     <= 1'b0;
      r_src0_sel  <= 1'b0;
      r_src1_sel  <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_width <= '0;
      r_br_en     <= 1'b0;
      r_br_type   <= '0;
      r_jump      <= 1'b0;
      r_wb_sel    <= '0;
      r_mdu_en    <= 1'b0;
      r_mdu_op    <= '0;
      r_illegal   <= 1'b0;
      r_lp        <= 1'b0;
      r_lp_rd     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_lp    <= 1'b0;
    end else begin
      r_lp    <= w_xfer && r_mem_re;
      r_lp_rd <= r_wa;
      if (w_accept) begin
        r_valid     <= 1'b1;
        r_pc        <= in_pc;
        r_alu_op    <= w_alu_op;
        r_imm       <= w_imm;
        r_ra0       <= w_ra0;
        r_ra1       <= w_ra1;
        r_wa        <= w_wa;
        r_rf_we     <= w_rf_we;
        r_src0_sel  <= w_src0_sel;
        r_src1_sel  <= w_src1_sel;
        r_mem_re    <= w_mem_re;
        r_mem_we    <= w_mem_we;
        r_mem_width <= w_mem_width;
        r_br_en     <= w_br_en;
        r_br_type   <= w_br_type;
        r_jump      <= w_jump;
        r_wb_sel    <= w_wb_sel;
        r_mdu_en    <= w_mdu_en;
        r_mdu_op    <= w_mdu_op;
        r_illegal   <= w_illegal;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid        = r_valid;
  assign out_pc           = r_pc;
  assign out_alu_op       = r_alu_op;
  assign out_imm          = r_imm;
  assign out_rf_ra0       = r_ra0;
  assign out_rf_ra1       = r_ra1;
  assign out_rf_wa        = r_wa;
  assign out_rf_we        = r_rf_we;
  assign out_alu_src0_sel = r_src0_sel;
  assign out_alu_src1_sel = r_src1_sel;
  assign out_mem_re       = r_mem_re;
  assign out_mem_we       = r_mem_we;
  assign out_mem_width    = r_mem_width;
  assign out_br_en        = r_br_en;
  assign out_br_type      = r_br_type;
  assign out_jump         = r_jump;
  assign out_wb_sel       = r_wb_sel;
  assign out_mdu_en       = r_mdu_en;
  assign out_mdu_op       = r_mdu_op;
  assign out_illegal      = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expected values are hand-decoded.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_alu_op;
  logic [31:0] out_imm;
  logic [4:0]  out_rf_ra0;
  logic [4:0]  out_rf_ra1;
  logic [4:0]  out_rf_wa;
  logic        out_rf_we;
  logic        out_alu_src0_sel;
  logic        out_alu_src1_sel;
  logic        out_mem_re;
  logic        out_mem_we;
  logic [2:0]  out_mem_width;
  logic        out_br_en;
  logic [2:0]  out_br_type;
  logic        out_jump;
  logic [1:0]  out_wb_sel;
  logic        out_mdu_en;
  logic [2:0]  out_mdu_op;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.XLEN(32), .RF_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_inst          (in_inst),
    .in_pc            (in_pc),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_alu_op       (out_alu_op),
    .out_imm          (out_imm),
    .out_rf_ra0       (out_rf_ra0),
    .out_rf_ra1       (out_rf_ra1),
    .out_rf_wa        (out_rf_wa),
    .out_rf_we        (out_rf_we),
    .out_alu_src0_sel (out_alu_src0_sel),
    .out_alu_src1_sel (out_alu_src1_sel),
    .out_mem_re       (out_mem_re),
    .out_mem_we       (out_mem_we),
    .out_mem_width    (out_mem_width),
    .out_br_en        (out_br_en),
    .out_br_type      (out_br_type),
    .out_jump         (out_jump),
    .out_wb_sel       (out_wb_sel),
    .out_mdu_en       (out_mdu_en),
    .out_mdu_op       (out_mdu_op),
    .out_illegal      (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one instruction with EX ready; it lands in the output register
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    in_inst   = inst;
    in_pc     = pc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;
    flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imm",   64'(out_imm),   64'd0);
    chk("rst_we",    64'(out_rf_we), 64'd0);
    chk("rst_wa",    64'(out_rf_wa), 64'd0);
    rst = 1'b0;

    // addi x1,x0,5
    in_inst = 32'h00500093; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("addi_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", 64'(out_valid),        64'd1);
    chk("addi_op",    64'(out_alu_op),       64'h0);
    chk("addi_imm",   64'(out_imm),          64'd5);
    chk("addi_wa",    64'(out_rf_wa),        64'd1);
    chk("addi_we",    64'(out_rf_we),        64'd1);
    chk("addi_src0",  64'(out_alu_src0_sel), 64'd1);
    chk("addi_src1",  64'(out_alu_src1_sel), 64'd0);
    chk("addi_pc",    64'(out_pc),           64'h100);

    // backpressure: addi x2,x0,7 offered while EX stalls 3 cycles
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00700113; in_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_pc",    64'(out_pc),    64'h100);
      chk("hold_imm",   64'(out_imm),   64'd5);
      chk("hold_wa",    64'(out_rf_wa), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rel_valid", 64'(out_valid), 64'd1);
    chk("rel_pc",    64'(out_pc),    64'h104);
    chk("rel_imm",   64'(out_imm),   64'd7);
    tick();
    chk("rel_bubble", 64'(out_valid), 64'd0);

    // lw x5,0(x2)
    issue(32'h00012283, 32'h200);
    chk("lw_valid", 64'(out_valid),     64'd1);
    chk("lw_re",    64'(out_mem_re),    64'd1);
    chk("lw_wb",    64'(out_wb_sel),    64'd1);
    chk("lw_wa",    64'(out_rf_wa),     64'd5);
    chk("lw_ra0",   64'(out_rf_ra0),    64'd2);
    chk("lw_width", 64'(out_mem_width), 64'd2);
    tick();  // lw transfers at this edge
    chk("lw_gone", 64'(out_valid), 64'd0);
    // lui x5 reads nothing: no stall
    in_inst = 32'h123452b7; in_pc = 32'h204; in_valid = 1'b1;
    #1;
    chk("lui_no_stall", 64'(in_ready), 64'd1);
    // add x6,x5,x5 depends on the load
    in_inst = 32'h00528333;
    #1;
    chk("lu_stall", 64'(in_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    chk("lu_ready_again", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("add_valid", 64'(out_valid),        64'd1);
    chk("add_wa",    64'(out_rf_wa),        64'd6);
    chk("add_ra0",   64'(out_rf_ra0),       64'd5);
    chk("add_ra1",   64'(out_rf_ra1),       64'd5);
    chk("add_src1",  64'(out_alu_src1_sel), 64'd1);
    chk("add_pc",    64'(out_pc),           64'h204);

    // flush with a held bundle and a pending offer
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h300; flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("reoffer_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("reoffer_valid", 64'(out_valid), 64'd1);
    chk("reoffer_pc",    64'(out_pc),    64'h300);

    // mul x3,x1,x2
    issue(32'h022081b3, 32'h400);
`ifdef RV32M_EN
    chk("mul_mdu_en", 64'(out_mdu_en),  64'd1);
    chk("mul_mdu_op", 64'(out_mdu_op),  64'd0);
    chk("mul_wa",     64'(out_rf_wa),   64'd3);
    chk("mul_we",     64'(out_rf_we),   64'd1);
    chk("mul_ill",    64'(out_illegal), 64'd0);
`else
    chk("mul_ill",    64'(out_illegal), 64'd1);
    chk("mul_we",     64'(out_rf_we),   64'd0);
    chk("mul_mdu_en", 64'(out_mdu_en),  64'd0);
`endif

    // slli x1,x1,32: shamt[5] set
    issue(32'h02009093, 32'h404);
    chk("slli32_ill", 64'(out_illegal), 64'd1);
    chk("slli32_we",  64'(out_rf_we),   64'd0);

    // jal x1,8
    issue(32'h008000ef, 32'h408);
    chk("jal_imm",  64'(out_imm),          64'd8);
    chk("jal_jump", 64'(out_jump),         64'd1);
    chk("jal_wb",   64'(out_wb_sel),       64'd2);
    chk("jal_src0", 64'(out_alu_src0_sel), 64'd0);
    chk("jal_we",   64'(out_rf_we),        64'd1);

    // sub x3,x1,x2
    issue(32'h402081b3, 32'h40c);
    chk("sub_op",  64'(out_alu_op),  64'b1000);
    chk("sub_ill", 64'(out_illegal), 64'd0);

    // srai x1,x1,3
    issue(32'h4030d093, 32'h410);
    chk("srai_op",  64'(out_alu_op), 64'b1101);
    chk("srai_imm", 64'(out_imm),    64'd3);

    // addi x1,x0,-1: sign extension
    issue(32'hfff00093, 32'h414);
    chk("neg_imm", 64'(out_imm),    64'hffffffff);
    chk("neg_op",  64'(out_alu_op), 64'h0);

    // beq x1,x2,16
    issue(32'h00208863, 32'h418);
    chk("beq_br",   64'(out_br_en),        64'd1);
    chk("beq_type", 64'(out_br_type),      64'd0);
    chk("beq_imm",  64'(out_imm),          64'd16);
    chk("beq_we",   64'(out_rf_we),        64'd0);
    chk("beq_src0", 64'(out_alu_src0_sel), 64'd0);
    chk("beq_ra1",  64'(out_rf_ra1),       64'd2);

    // sw x5,4(x2)
    issue(32'h00512223, 32'h41c);
    chk("sw_we",  64'(out_mem_we), 64'd1);
    chk("sw_rfwe",64'(out_rf_we),  64'd0);
    chk("sw_ra1", 64'(out_rf_ra1), 64'd5);
    chk("sw_imm", 64'(out_imm),    64'd4);

    // lui x5,0x12345
    issue(32'h123452b7, 32'h420);
    chk("lui_op",  64'(out_alu_op), 64'b1100);
    chk("lui_imm", 64'(out_imm),    64'h12345000);

    // load funct3 011 and an unknown opcode
    issue(32'h00013283, 32'h424);
    chk("ld_ill", 64'(out_illegal), 64'd1);
    chk("ld_re",  64'(out_mem_re),  64'd0);
    issue(32'h0000007f, 32'h428);
    chk("unk_ill", 64'(out_illegal), 64'd1);

    // addi x0,x0,1: rd=0 suppresses the write
    issue(32'h00100013, 32'h42c);
    chk("x0_we",  64'(out_rf_we),   64'd0);
    chk("x0_ill", 64'(out_illegal), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
